// File: rtl/isp_video_pkg.sv
// rtl/isp_video_pkg.sv - shared encodings and constants for the ISP video source
package isp_video_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pat_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic SYNC_ACTIVE = 1'b0;
    localparam int   CNT_W       = 16;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][23:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    function automatic logic [23:0] grey(input logic [7:0] level);
        return {level, level, level};
    endfunction

endpackage

// File: rtl/isp_video_timing.sv
// rtl/isp_video_timing.sv - frame counters, IDLE/RUN control and sync/href decode
module isp_video_timing
    import isp_video_pkg::*;
#(
    parameter int H_ACTIVE = 8,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 1,
    parameter int V_ACTIVE = 10,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             vsync,
    output logic             hsync,
    output logic             href,
    output logic             frame_start,
    output logic [15:0]      frame_cnt,
    output logic             busy,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             pix_valid,
    output logic             frame_origin
);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic [CNT_W-1:0] H_SYN_E = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYN_E = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_S = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_E = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_S = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_E = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    state_e           state, state_nx;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_nx, v_nx;
    logic             run, eof, href_d;

    assign run          = (state == ST_RUN);
    assign eof          = run && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign href_d       = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E) &&
                          (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
    assign pix_x        = h_cnt - H_ACT_S;
    assign pix_y        = v_cnt - V_ACT_S;
    assign pix_valid    = run && href_d;
    assign frame_origin = run && (h_cnt == '0) && (v_cnt == '0);
    assign busy         = run;

    always_comb begin
        state_nx = state;
        h_nx     = h_cnt;
        v_nx     = v_cnt;
        case (state)
            ST_IDLE: begin
                h_nx = '0;
                v_nx = '0;
                if (enable) state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (h_cnt == H_LAST) begin
                    h_nx = '0;
                    if (v_cnt == V_LAST) begin
                        v_nx = '0;
                        // Stop requests only take effect on the frame boundary
                        if (!enable) state_nx = ST_IDLE;
                    end else begin
                        v_nx = v_cnt + CNT_W'(1);
                    end
                end else begin
                    h_nx = h_cnt + CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            vsync       <= ~SYNC_ACTIVE;
            hsync       <= ~SYNC_ACTIVE;
            href        <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_nx;
            h_cnt       <= h_nx;
            v_cnt       <= v_nx;
            vsync       <= (run && (v_cnt < V_SYN_E)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            hsync       <= (run && (h_cnt < H_SYN_E)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            href        <= pix_valid;
            frame_start <= frame_origin;
            if (eof) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/isp_video_src.sv
// rtl/isp_video_src.sv - ISP video pattern source: frame timing plus RGB888 test patterns
module isp_video_src
    import isp_video_pkg::*;
#(
    parameter int H_ACTIVE  = 8,
    parameter int H_FP      = 2,
    parameter int H_SYNC    = 1,
    parameter int H_BP      = 1,
    parameter int V_ACTIVE  = 10,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 1,
    parameter int CHK_SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic        per_frame_vsync,
    output logic        per_frame_hsync,
    output logic        per_frame_href,
    output logic [7:0]  per_img_red,
    output logic [7:0]  per_img_green,
    output logic [7:0]  per_img_blue,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

    logic [CNT_W-1:0] pix_x, pix_y;
    logic             pix_valid, frame_origin;
    pat_e             mode_q;
    logic [23:0]      solid_q, rgb_d, rgb_q;
    logic [2:0]       bar_idx;
    logic [7:0]       ramp;
    logic             chk;

    isp_video_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .vsync        (per_frame_vsync),
        .hsync        (per_frame_hsync),
        .href         (per_frame_href),
        .frame_start  (frame_start),
        .frame_cnt    (frame_cnt),
        .busy         (busy),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_valid    (pix_valid),
        .frame_origin (frame_origin)
    );

    assign bar_idx = 3'(pix_x / BAR_W);
    assign ramp    = 8'(pix_x + pix_y);
    assign chk     = 1'((pix_x >> CHK_SHIFT) ^ (pix_y >> CHK_SHIFT));

    always_comb begin
        rgb_d = 24'h0;
        case (mode_q)
            PAT_BARS:  rgb_d = BAR_RGB[bar_idx];
            PAT_RAMP:  rgb_d = grey(ramp);
            PAT_CHECK: rgb_d = chk ? 24'hFFFFFF : 24'h000000;
            PAT_SOLID: rgb_d = solid_q;
            default:   rgb_d = 24'h0;
        endcase
    end

    // Pattern settings are captured once per frame so a frame is never mixed
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= PAT_BARS;
            solid_q <= 24'h0;
            rgb_q   <= 24'h0;
        end else begin
            if (frame_origin) begin
                mode_q  <= pat_e'(mode);
                solid_q <= solid_rgb;
            end
            rgb_q <= pix_valid ? rgb_d : 24'h0;
        end
    end

    assign per_img_red   = rgb_q[23:16];
    assign per_img_green = rgb_q[15:8];
    assign per_img_blue  = rgb_q[7:0];

endmodule

// File: tb/tb_isp_video_src.sv
// tb/tb_isp_video_src.sv - self-checking bench for isp_video_src against a frame-position model
module tb_isp_video_src;

    localparam int HA = 8, HF = 2, HS = 1, HB = 1;
    localparam int VA = 10, VF = 1, VS = 2, VB = 1, CS = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic        per_frame_vsync, per_frame_hsync, per_frame_href;
    logic [7:0]  per_img_red, per_img_green, per_img_blue;
    logic        frame_start, busy;
    logic [15:0] frame_cnt;
    logic [44:0] obs;

    int checks = 0;
    int errors = 0;
    int done = 0;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    isp_video_src #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CHK_SHIFT(CS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .mode            (mode),
        .solid_rgb       (solid_rgb),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_hsync (per_frame_hsync),
        .per_frame_href  (per_frame_href),
        .per_img_red     (per_img_red),
        .per_img_green   (per_img_green),
        .per_img_blue    (per_img_blue),
        .frame_start     (frame_start),
        .frame_cnt       (frame_cnt),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    assign obs = {per_frame_vsync, per_frame_hsync, per_frame_href,
                  per_img_red, per_img_green, per_img_blue, frame_start, busy, frame_cnt};

    task automatic check(input string tag, input logic [44:0] o, input logic [44:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Pixel colour for output position k of a frame, straight from the pattern rules
    function automatic logic [23:0] exp_rgb(int k, logic [1:0] m, logic [23:0] s);
        int x = (k % HT) - (HS + HB);
        int y = (k / HT) - (VS + VB);
        logic [7:0] g;
        if (x < 0 || x >= HA || y < 0 || y >= VA) return 24'h0;
        case (m)
            2'd0: return bars[x / (HA / 8)];
            2'd1: begin
                g = 8'(x + y);
                return {g, g, g};
            end
            2'd2: return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
            default: return s;
        endcase
    endfunction

    function automatic logic [44:0] exp_vec(int k, logic [1:0] m, logic [23:0] s, bit stop, int nd);
        int h = k % HT;
        int v = k / HT;
        logic vs = (v >= VS);
        logic hs = (h >= HS);
        logic hr = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        logic fs = (k == 0);
        logic bz = !(stop && k == FT - 1);
        logic [15:0] fc = 16'(nd + ((k == FT - 1) ? 1 : 0));
        return {vs, hs, hr, exp_rgb(k, m, s), fs, bz, fc};
    endfunction

    function automatic logic [44:0] idle_vec(int fc);
        return {1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 16'(fc)};
    endfunction

    task automatic start_run(input logic [1:0] m, input logic [23:0] s);
        mode = m;
        solid_rgb = s;
        enable = 1'b1;
        @(negedge clk);
        check("run_entry", obs, {1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b1, 16'(done)});
        @(negedge clk);
    endtask

    task automatic run_frame(input int f, input logic [1:0] m, input logic [23:0] s,
                             input logic [1:0] nm, input logic [23:0] ns,
                             input bit stop, input int rst_k);
        int junk_k = int'($urandom_range(5, 100));
        int drop_k = int'($urandom_range(20, 140));
        int vlow = 0;
        int hcnt = 0;
        for (int k = 0; k < FT; k++) begin
            check($sformatf("frame%0d_k%0d", f, k), obs, exp_vec(k, m, s, stop, done));
            check("href_in_vsync", 45'(per_frame_href & ~per_frame_vsync), 45'(0));
            if (!per_frame_vsync) vlow++;
            if (per_frame_href) hcnt++;
            if (k == rst_k) begin
                rst = 1'b1;
                @(negedge clk);
                check("reset_mid_frame", obs, idle_vec(0));
                done = 0;
                rst = 1'b0;
                enable = 1'b0;
                return;
            end
            if (k == junk_k) begin
                mode = (m == 2'd3) ? 2'd0 : 2'($urandom_range(0, 3));
                solid_rgb = 24'($urandom);
            end
            if (k == 150) begin
                mode = nm;
                solid_rgb = ns;
            end
            if (stop && k == drop_k) enable = 1'b0;
            @(negedge clk);
        end
        done++;
        check($sformatf("frame%0d_vsync_low", f), 45'(vlow), 45'(VS * HT));
        check($sformatf("frame%0d_href_cnt", f), 45'(hcnt), 45'(HA * VA));
        if (stop) check($sformatf("frame%0d_stop_idle", f), obs, idle_vec(done));
    endtask

    initial begin
        logic [1:0]  r1, r2, r3;
        logic [23:0] s1, s2, s3, sr;
        int rk;
        r1 = 2'($urandom_range(0, 3));
        r2 = 2'($urandom_range(0, 3));
        r3 = 2'($urandom_range(0, 3));
        s1 = 24'($urandom);
        s2 = 24'($urandom);
        s3 = 24'($urandom);
        sr = 24'($urandom);

        repeat (3) @(negedge clk);
        check("rst_vsync", 45'(per_frame_vsync), 45'(1));
        check("rst_hsync", 45'(per_frame_hsync), 45'(1));
        check("rst_href", 45'(per_frame_href), 45'(0));
        check("rst_rgb", 45'({per_img_red, per_img_green, per_img_blue}), 45'(0));
        check("rst_frame_start", 45'(frame_start), 45'(0));
        check("rst_frame_cnt", 45'(frame_cnt), 45'(0));
        check("rst_busy", 45'(busy), 45'(0));
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("idle_hold", obs, idle_vec(0));
        end

        start_run(2'd0, 24'h0);
        run_frame(0, 2'd0, 24'h0, 2'd0, 24'h0, 1'b1, -1);
        repeat (3) begin
            @(negedge clk);
            check("idle_after_stop", obs, idle_vec(1));
        end
        check("frame_cnt_after_stop", 45'(frame_cnt), 45'(1));

        start_run(2'd1, sr);
        run_frame(1, 2'd1, sr, 2'd2, sr, 1'b0, -1);
        run_frame(2, 2'd2, sr, 2'd3, 24'h12AB34, 1'b0, -1);
        run_frame(3, 2'd3, 24'h12AB34, 2'd0, 24'h0, 1'b0, -1);
        run_frame(4, 2'd0, 24'h0, r1, s1, 1'b0, -1);
        run_frame(5, r1, s1, r2, s2, 1'b1, -1);
        repeat (2) begin
            @(negedge clk);
            check("idle_after_run", obs, idle_vec(6));
        end

        start_run(r3, s3);
        rk = (VS + VB + int'($urandom_range(0, VA - 1))) * HT + HS + HB + int'($urandom_range(0, HA - 1));
        run_frame(6, r3, s3, r3, s3, 1'b0, rk);
        repeat (3) begin
            @(negedge clk);
            check("idle_after_reset", obs, idle_vec(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
